// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the RV32I multicycle control path: opcodes, FSM states
// and the datapath mux / ALU operation select codes.
package multicycle_control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // 17 behavioural states do not fit 4 bits, so R-type and I-type execute
    // share EXEC and pick the ALU B operand from the latched opcode.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC      = 4'd7,
        S_LUI       = 4'd8,
        S_AUIPC     = 4'd9,
        S_ALU_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JAL       = 4'd12,
        S_JALR      = 4'd13,
        S_LINK      = 4'd14,
        S_HALT      = 4'd15
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_control_branch_eval.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
// Purely combinational; flags the two reserved funct3 encodings.
module multicycle_control_branch_eval (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the RV32I multicycle core: sequences fetch, decode,
// execute, memory and writeback, and drives all datapath strobes and selects.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | post-reset hold, RESET_HOLD cycles
// FETCH     | read instruction at PC, PC+4 -> PC and IR latch on mem_ready
// DECODE    | alu_out <= old_pc + imm, dispatch on opcode
// MEM_ADR   | effective address rs1 + imm
// MEM_READ  | load request at alu_out until mem_ready
// MEM_WB    | write load data to rd
// MEM_WRITE | store request at alu_out until mem_ready
// EXEC      | R-type (rs2) or I-type (imm) ALU operation
// LUI       | pass immediate through the ALU
// AUIPC     | old_pc + imm
// ALU_WB    | write alu_out to rd
// BRANCH    | compare rs1/rs2, load target into PC if taken
// JAL       | PC <= target, alu_out <= old_pc + 4
// JALR      | PC <= rs1 + imm
// LINK      | rd <= old_pc + 4
// HALT      | stopped until reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       illegal_q, illegal_d;
    logic       br_taken, br_bad;

    multicycle_control_branch_eval u_branch_eval (
        .funct3     (funct3),
        .zero       (zero),
        .alu_lt     (alu_lt),
        .alu_ltu    (alu_ltu),
        .taken      (br_taken),
        .bad_funct3 (br_bad)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        illegal_d  = illegal_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALU_OUT;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                // Strobes only on the completing cycle so PC advances once.
                if (mem_ready) begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    OP_SYSTEM: state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = (opcode == OP_RTYPE) ? SRC_B_RS2 : SRC_B_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_PASSB;
                state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_SUB;
                if (br_bad) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    pc_write = br_taken;
                    state_d  = S_FETCH;
                end
            end
            S_JAL: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_d    = S_LINK;
            end
            S_LINK: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule
